// File: rtl/pipeline_pkg.sv
// Shared pipeline types and helpers for the decode/execute boundary.
package pipeline_pkg;

   localparam int unsigned ALUOP_W = 4;
   localparam logic [4:0]  REG_X0  = 5'd0;

   typedef struct packed {
      logic               regWrite;
      logic               memRead;
      logic               memWrite;
      logic               memToReg;
      logic               aluSrc;
      logic               branch;
      logic [ALUOP_W-1:0] aluOp;
   } ex_ctrl_t;

   localparam ex_ctrl_t CTRL_BUBBLE = '0;

   // Increment that sticks at max instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] cur, input logic [31:0] max);
      return (cur == max) ? cur : cur + 32'd1;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: ID reads a register that the load in EX has not yet produced.
module load_use_detect
   import pipeline_pkg::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_valid,
   input  logic       ex_memRead,
   input  logic [4:0] ex_rd,
   output logic       lu
);

   // Only real source reads against a non-x0 load destination count.
   always_comb begin
      lu = ex_valid & ex_memRead & (ex_rd != REG_X0) & id_valid &
           ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use interlock, WB->ID bypass and event counters.
module id_ex_stage #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ALUOP_W = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_rs1_data,
   input  logic [XLEN-1:0]    id_rs2_data,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [4:0]         id_rs1,
   input  logic [4:0]         id_rs2,
   input  logic               id_uses_rs1,
   input  logic               id_uses_rs2,
   input  logic [4:0]         id_rd,
   input  logic               id_regWrite,
   input  logic               id_memRead,
   input  logic               id_memWrite,
   input  logic               id_memToReg,
   input  logic               id_aluSrc,
   input  logic               id_branch,
   input  logic [ALUOP_W-1:0] id_aluOp,
   input  logic               wb_regWrite,
   input  logic [4:0]         wb_rd,
   input  logic [XLEN-1:0]    wb_data,
   input  logic               ex_flush,
   output logic               stall,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_rs1_data,
   output logic [XLEN-1:0]    ex_rs2_data,
   output logic [XLEN-1:0]    ex_imm,
   output logic [4:0]         ex_rs1,
   output logic [4:0]         ex_rs2,
   output logic [4:0]         ex_rd,
   output logic               ex_regWrite,
   output logic               ex_memRead,
   output logic               ex_memWrite,
   output logic               ex_memToReg,
   output logic               ex_aluSrc,
   output logic               ex_branch,
   output logic [ALUOP_W-1:0] ex_aluOp,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   import pipeline_pkg::*;

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic            lu;
   ex_ctrl_t        id_ctrl;
   ex_ctrl_t        ex_ctrl;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic [31:0]     stall_inc;
   logic [31:0]     flush_inc;

   load_use_detect u_load_use_detect (
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_valid    (ex_valid),
      .ex_memRead  (ex_ctrl.memRead),
      .ex_rd       (ex_rd),
      .lu          (lu)
   );

   // A flush kills the ID instruction, so it can never be the cause of a stall.
   always_comb stall = lu & ~ex_flush;

   // Gate control with id_valid and pick bypassed register data from WB.
   always_comb begin
      id_ctrl.regWrite = id_regWrite & id_valid;
      id_ctrl.memRead  = id_memRead  & id_valid;
      id_ctrl.memWrite = id_memWrite & id_valid;
      id_ctrl.memToReg = id_memToReg & id_valid;
      id_ctrl.aluSrc   = id_aluSrc   & id_valid;
      id_ctrl.branch   = id_branch   & id_valid;
      id_ctrl.aluOp    = id_aluOp;
      rs1_fwd = (wb_regWrite && (wb_rd != REG_X0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
      rs2_fwd = (wb_regWrite && (wb_rd != REG_X0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
      stall_inc = sat_inc(32'(stall_cnt), CNT_MAX);
      flush_inc = sat_inc(32'(flush_cnt), CNT_MAX);
   end

   // Pipeline register: reset, flush and load-use all collapse to the same all-zero bubble.
   always_ff @(posedge clk) begin
      if (rst || ex_flush || lu) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= CTRL_BUBBLE;
      end else begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_rs1_data <= rs1_fwd;
         ex_rs2_data <= rs2_fwd;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_ctrl     <= id_ctrl;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall)    stall_cnt <= stall_inc[CNT_W-1:0];
         if (ex_flush) flush_cnt <= flush_inc[CNT_W-1:0];
      end
   end

   // Unpack registered control onto the EX-facing ports.
   always_comb begin
      ex_regWrite = ex_ctrl.regWrite;
      ex_memRead  = ex_ctrl.memRead;
      ex_memWrite = ex_ctrl.memWrite;
      ex_memToReg = ex_ctrl.memToReg;
      ex_aluSrc   = ex_ctrl.aluSrc;
      ex_branch   = ex_ctrl.branch;
      ex_aluOp    = ex_ctrl.aluOp;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the EX register contents and event counts.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, id_valid, id_uses_rs1, id_uses_rs2;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
   logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
   logic        id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_branch;
   logic [3:0]  id_aluOp;
   logic        wb_regWrite, ex_flush;

   logic        stall, ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch;
   logic [3:0]  ex_aluOp;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_stall, s_ex_valid;
   logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
   logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
   logic        s_ex_regWrite, s_ex_memRead, s_ex_memWrite, s_ex_memToReg, s_ex_aluSrc, s_ex_branch;
   logic [3:0]  s_ex_aluOp;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
      .id_memWrite(id_memWrite), .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc),
      .id_branch(id_branch), .id_aluOp(id_aluOp), .wb_regWrite(wb_regWrite),
      .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush), .stall(stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
      .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc),
      .ex_branch(ex_branch), .ex_aluOp(ex_aluOp), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter copy on the same stimulus so stall saturation is reachable quickly.
   id_ex_stage #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
      .id_memWrite(id_memWrite), .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc),
      .id_branch(id_branch), .id_aluOp(id_aluOp), .wb_regWrite(wb_regWrite),
      .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush), .stall(s_stall),
      .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1_data(s_ex_rs1_data),
      .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
      .ex_rd(s_ex_rd), .ex_regWrite(s_ex_regWrite), .ex_memRead(s_ex_memRead),
      .ex_memWrite(s_ex_memWrite), .ex_memToReg(s_ex_memToReg), .ex_aluSrc(s_ex_aluSrc),
      .ex_branch(s_ex_branch), .ex_aluOp(s_ex_aluOp), .stall_cnt(s_stall_cnt),
      .flush_cnt(s_flush_cnt)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, a, b, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mr, mw, m2r, as, br;
      logic [3:0]  op;
   } exm_t;

   exm_t        m;
   bit          m_known = 1'b0;
   longint      n_stall = 0;
   longint      n_flush = 0;
   int unsigned total = 0;
   int unsigned passed = 0;
   int unsigned fails = 0;
   bit          last_stall = 1'b0;

   function automatic logic [31:0] sat(input longint n, input int unsigned w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return 32'((n > mx) ? mx : n);
   endfunction

   task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
      total++;
      assert (o === e) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // One clock: check stall mid-cycle, advance the model at the edge, check state after it.
   task automatic cycle();
      exm_t obs;
      bit   lu_e;
      @(negedge clk);
      lu_e = m.valid && m.mr && (m.rd != 5'd0) && id_valid &&
             ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
      if (m_known) chk("stall", stall, lu_e && !ex_flush);
      last_stall = lu_e && !ex_flush;
      if (rst) begin
         m = '0; n_stall = 0; n_flush = 0; m_known = 1'b1;
      end else if (ex_flush || lu_e) begin
         if (ex_flush) n_flush++;
         else n_stall++;
         m = '0;
      end else begin
         m.valid = id_valid;
         m.pc    = id_pc;
         m.a     = (wb_regWrite && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
         m.b     = (wb_regWrite && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
         m.imm   = id_imm;
         m.rs1   = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
         m.rw    = id_regWrite && id_valid;
         m.mr    = id_memRead  && id_valid;
         m.mw    = id_memWrite && id_valid;
         m.m2r   = id_memToReg && id_valid;
         m.as    = id_aluSrc   && id_valid;
         m.br    = id_branch   && id_valid;
         m.op    = id_aluOp;
      end
      @(posedge clk);
      #1;
      obs = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch, ex_aluOp};
      if (m_known) begin
         chk("ex_state", obs, m);
         chk("stall_cnt", stall_cnt, sat(n_stall, 16));
         chk("flush_cnt", flush_cnt, sat(n_flush, 16));
         chk("sat_stall_cnt", s_stall_cnt, sat(n_stall, 4));
         chk("sat_flush_cnt", s_flush_cnt, sat(n_flush, 4));
      end
   endtask

   task automatic id_clear();
      id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd = '0;
      id_regWrite = 1'b0; id_memRead = 1'b0; id_memWrite = 1'b0; id_memToReg = 1'b0;
      id_aluSrc = 1'b0; id_branch = 1'b0; id_aluOp = '0;
   endtask

   task automatic id_lw(input logic [4:0] rd);
      id_clear();
      id_valid = 1'b1; id_pc = 32'h100; id_rs1 = 5'd2; id_uses_rs1 = 1'b1; id_rs1_data = 32'h40;
      id_imm = 32'h8; id_rd = rd; id_regWrite = 1'b1; id_memRead = 1'b1; id_memToReg = 1'b1;
      id_aluSrc = 1'b1;
   endtask

   task automatic id_add(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2);
      id_clear();
      id_valid = 1'b1; id_pc = 32'h104; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1;
      id_uses_rs2 = u2; id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_rd = 5'd6;
      id_regWrite = 1'b1; id_aluOp = 4'h2;
   endtask

   task automatic id_rand();
      id_valid = ($urandom % 8) != 0;
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom % 4); id_rs2 = 5'($urandom % 4); id_rd = 5'($urandom % 4);
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_regWrite = 1'($urandom); id_memRead = 1'($urandom); id_memWrite = 1'($urandom);
      id_memToReg = 1'($urandom); id_aluSrc = 1'($urandom); id_branch = 1'($urandom);
      id_aluOp = 4'($urandom);
   endtask

   initial begin
      rst = 1'b1; ex_flush = 1'b0;
      wb_regWrite = 1'b0; wb_rd = '0; wb_data = '0;
      id_rand();
      id_valid = 1'b1;

      // Reset held two cycles with a valid ID instruction present.
      cycle();
      cycle();
      chk("rst_ex_valid", ex_valid, 1'b0);
      chk("rst_ex_memRead", ex_memRead, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_cnt", {stall_cnt, flush_cnt}, 32'd0);
      rst = 1'b0;

      // Load-use: lw x5 then add x6,x5,x7.
      id_lw(5'd5);
      cycle();
      id_add(5'd5, 5'd7, 1'b1, 1'b1);
      #1 chk("lu_stall_comb", stall, 1'b1);
      cycle();
      chk("lu_bubble", ex_valid, 1'b0);
      chk("lu_stall_cnt", stall_cnt, 16'd1);
      cycle();
      chk("lu_reissue_rs1", ex_rs1, 5'd5);
      chk("lu_reissue_valid", ex_valid, 1'b1);
      chk("lu_stall_drop", stall, 1'b0);

      // No false stalls: rd=x0 load, and an unused rs2 that matches.
      id_lw(5'd0);
      cycle();
      id_add(5'd0, 5'd0, 1'b1, 1'b1);
      cycle();
      id_lw(5'd5);
      cycle();
      id_add(5'd1, 5'd5, 1'b1, 1'b0);
      cycle();
      chk("nofalse_stall_cnt", stall_cnt, 16'd1);

      // Flush in the same cycle as a load-use hazard.
      id_lw(5'd5);
      cycle();
      id_add(5'd5, 5'd7, 1'b1, 1'b0);
      ex_flush = 1'b1;
      #1 chk("flush_lu_stall", stall, 1'b0);
      cycle();
      ex_flush = 1'b0;
      chk("flush_bubble", ex_valid, 1'b0);
      chk("flush_cnt1", flush_cnt, 16'd1);
      chk("flush_stall_cnt", stall_cnt, 16'd1);

      // WB bypass onto rs2, then the x0 case.
      id_add(5'd1, 5'd3, 1'b1, 1'b1);
      id_rs2_data = 32'h0;
      wb_regWrite = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
      cycle();
      chk("bypass_rs2", ex_rs2_data, 32'hDEADBEEF);
      id_rs2 = 5'd0; wb_rd = 5'd0;
      cycle();
      chk("bypass_x0", ex_rs2_data, 32'h0);
      wb_regWrite = 1'b0;

      // Reset arriving during a stall.
      id_lw(5'd5);
      cycle();
      id_add(5'd5, 5'd7, 1'b1, 1'b0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_mid_ex_valid", ex_valid, 1'b0);
      chk("rst_mid_stall", stall, 1'b0);
      chk("rst_mid_cnt", {stall_cnt, flush_cnt}, 32'd0);

      // Randomized traffic; ID is held upstream while stalled.
      for (int i = 0; i < 3000; i++) begin
         if (!last_stall) id_rand();
         wb_regWrite = 1'($urandom); wb_rd = 5'($urandom % 4); wb_data = $urandom;
         ex_flush = ($urandom % 10) == 0;
         cycle();
      end
      ex_flush = 1'b0; wb_regWrite = 1'b0;

      // Stall counter saturation on the narrow copy.
      rst = 1'b1; cycle(); rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         id_lw(5'd5);
         cycle();
         id_add(5'd5, 5'd7, 1'b1, 1'b0);
         cycle();
      end
      chk("sat4_stall", s_stall_cnt, 4'hF);
      chk("stall_cnt20", stall_cnt, 16'd20);

      // Flush counter saturation at full width.
      rst = 1'b1; cycle(); rst = 1'b0;
      id_clear();
      ex_flush = 1'b1;
      for (int i = 0; i < 65539; i++) cycle();
      ex_flush = 1'b0;
      chk("flush_sat", flush_cnt, 16'hFFFF);
      cycle();
      chk("flush_sat_hold", flush_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
